// File: rtl/legv8_fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch front end.
package legv8_fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] DEFAULT_PC_STEP  = 32'h0000_0001;

    // One buffered fetch: the instruction word tagged with the PC it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/legv8_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
module legv8_fetch_fifo
    import legv8_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while the count covers them.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/legv8_fetch_queue.sv
// LEGv8 fetch front end: owns the fetch PC, issues credit-limited imem reads,
// buffers PC-tagged responses and hands them to decode; redirect flushes all.
module legv8_fetch_queue
    import legv8_fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [ADDR_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_instr,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              issue;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]  credit_used;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // A slot is reserved for every read in flight, so a response always fits.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign issue       = !redirect && !fifo_full && (credit_used < CREDIT_LIMIT);

    assign imem_req  = issue && !reset;
    assign imem_addr = fetch_pc;

    assign fifo_push        = inflight && !redirect;
    assign push_entry.pc    = inflight_pc;
    assign push_entry.instr = imem_instr;
    assign fifo_pop         = out_valid && out_ready;

    assign out_valid = !fifo_empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign occupancy = fifo_count;

    // Fetch PC and in-flight tracking; a redirect kills the pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + PC_STEP;
            end
        end
    end

    legv8_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .flush      (redirect),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

endmodule

// File: tb/tb_legv8_fetch_queue.sv
// Self-checking bench for legv8_fetch_queue: directed vector table, a hand
// written asynchronous-reset sequence and a randomized run against a queue model.
module tb_legv8_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] prev_addr = 32'h0;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        int          e_occ;
    } vec_t;

    vec_t vecs[$];

    legv8_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(32'h1)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: word at address a holds a+100.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'd100;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; imem answers last cycle's address.
    task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        imem_instr  = mem_word(prev_addr);
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        #1;
        prev_addr = imem_addr;
    endtask

    task automatic checkOutput(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc, input int e_occ);
        check({tag, " imem_req"},  32'(imem_req),  32'(e_req));
        check({tag, " imem_addr"}, imem_addr,      e_addr);
        check({tag, " out_valid"}, 32'(out_valid), 32'(e_valid));
        check({tag, " occupancy"}, 32'(occupancy), 32'(e_occ));
        if (e_valid) begin
            check({tag, " out_pc"},    out_pc,    e_pc);
            check({tag, " out_instr"}, out_instr, mem_word(e_pc));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        imem_instr  = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 32'h0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    function automatic void add_vec(input logic rd, input logic [31:0] rpc, input logic rdy,
                                    input logic er, input logic [31:0] ea, input logic ev,
                                    input logic [31:0] ep, input int eo);
        vec_t v;
        v.redirect = rd; v.rpc = rpc; v.ready = rdy;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_occ = eo;
        vecs.push_back(v);
    endfunction

    // Randomized-run reference model: queue of buffered PCs plus one pending read.
    logic [31:0] q_pc[$];
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_pc;

    initial begin
        logic        r_red;
        logic        r_rdy;
        logic        e_req;
        logic [31:0] r_pc;
        int          stall_left;

        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0; imem_instr = 32'h0;

        // Startup, full stall, drain, redirect with data buffered, double redirect.
        add_vec(0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  0);
        add_vec(0, 32'h0,  0, 1, 32'h1,  0, 32'h0,  0);
        add_vec(0, 32'h0,  0, 1, 32'h2,  1, 32'h0,  1);
        add_vec(0, 32'h0,  0, 1, 32'h3,  1, 32'h0,  2);
        add_vec(0, 32'h0,  0, 0, 32'h4,  1, 32'h0,  3);
        add_vec(0, 32'h0,  0, 0, 32'h4,  1, 32'h0,  4);
        add_vec(0, 32'h0,  0, 0, 32'h4,  1, 32'h0,  4);
        add_vec(0, 32'h0,  0, 0, 32'h4,  1, 32'h0,  4);
        add_vec(0, 32'h0,  1, 0, 32'h4,  1, 32'h0,  4);
        add_vec(0, 32'h0,  1, 1, 32'h4,  1, 32'h1,  3);
        add_vec(0, 32'h0,  1, 1, 32'h5,  1, 32'h2,  2);
        add_vec(0, 32'h0,  1, 1, 32'h6,  1, 32'h3,  2);
        add_vec(0, 32'h0,  0, 1, 32'h7,  1, 32'h4,  2);
        add_vec(1, 32'h40, 0, 0, 32'h8,  1, 32'h4,  3);
        add_vec(0, 32'h0,  1, 1, 32'h40, 0, 32'h0,  0);
        add_vec(0, 32'h0,  1, 1, 32'h41, 0, 32'h0,  0);
        add_vec(0, 32'h0,  1, 1, 32'h42, 1, 32'h40, 1);
        add_vec(1, 32'h80, 1, 0, 32'h43, 1, 32'h41, 1);
        add_vec(1, 32'hC0, 1, 0, 32'h80, 0, 32'h0,  0);
        add_vec(0, 32'h0,  1, 1, 32'hC0, 0, 32'h0,  0);
        add_vec(0, 32'h0,  1, 1, 32'hC1, 0, 32'h0,  0);
        add_vec(0, 32'h0,  1, 1, 32'hC2, 1, 32'hC0, 1);

        $display("[TB] directed vector table (%0d cycles)", vecs.size());
        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                        vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_occ);
        end

        // Asynchronous reset in the middle of a cycle with two entries buffered.
        $display("[TB] asynchronous reset mid-stream");
        doReset();
        applyStimulus(0, 32'h0, 0); checkOutput("ar c0", 1, 32'h0, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 0); checkOutput("ar c1", 1, 32'h1, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 0); checkOutput("ar c2", 1, 32'h2, 1, 32'h0, 1);
        applyStimulus(0, 32'h0, 0); checkOutput("ar c3", 1, 32'h3, 1, 32'h0, 2);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar asserted", 0, 32'h0, 0, 32'h0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        applyStimulus(0, 32'h0, 1); checkOutput("ar rel0", 1, 32'h0, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 1); checkOutput("ar rel1", 1, 32'h1, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 1); checkOutput("ar rel2", 1, 32'h2, 1, 32'h0, 1);

        // Randomized traffic against the queue model.
        $display("[TB] randomized run");
        doReset();
        q_pc.delete();
        m_pc = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0;
        stall_left = 0;
        for (int i = 0; i < 800; i++) begin
            r_red = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       r_pc = 32'hFFFF_FFFE;
                default: r_pc = $urandom;
            endcase
            if (stall_left > 0) begin
                stall_left--;
                r_rdy = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                stall_left = $urandom_range(3, 10);
                r_rdy = 1'b0;
            end else begin
                r_rdy = ($urandom_range(0, 3) != 0);
            end

            applyStimulus(r_red, r_pc, r_rdy);
            e_req = !r_red && ((q_pc.size() + int'(m_pend)) < DEPTH);
            checkOutput($sformatf("rand%0d", i), e_req, m_pc, q_pc.size() != 0,
                        (q_pc.size() != 0) ? q_pc[0] : 32'h0, q_pc.size());

            if (r_red) begin
                q_pc.delete();
                m_pend = 1'b0;
                m_pc   = r_pc;
            end else begin
                if (q_pc.size() != 0 && r_rdy) void'(q_pc.pop_front());
                if (m_pend) q_pc.push_back(m_pend_pc);
                m_pend = e_req;
                if (e_req) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_fetch_queue.md
Name: legv8_fetch_queue

Overview:
Instruction-fetch front end for the LEGv8 datapath. It sits upstream of the decode/controller/register-file stage and downstream of the PC logic.
- Owns the fetch PC and issues reads to the instruction memory (one-cycle registered latency).
- Buffers returned instructions, tagged with their PC, in a small FIFO.
- Hands them to decode over a valid/ready handshake.
- A branch redirect flushes buffered and in-flight fetches and restarts at the target.

Parameters:
DEPTH, 4, FIFO entries (minimum 2; at least 3 needed for one instruction per cycle)
RESET_PC, 0, fetch PC after reset
PC_STEP, 1, PC increment per fetch (word-addressed instruction memory)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
imem_req  out  1  read request this cycle
imem_addr  out  32  read address, equals fetch_pc
imem_instr  in  32  read data, valid the cycle after imem_req
redirect  in  1  branch taken; one-cycle pulse
redirect_pc  in  32  branch target, sampled when redirect=1
out_valid  out  1  FIFO not empty
out_instr  out  32  instruction at FIFO head
out_pc  out  32  PC of instruction at FIFO head
out_ready  in  1  decode accepts head this cycle
occupancy  out  $clog2(DEPTH+1)  current FIFO count

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, inflight=0, count=0, read/write pointers=0. While reset is high: imem_req=0, out_valid=0, occupancy=0. out_instr and out_pc are don't-care while out_valid=0.
- Issue rule: imem_req = !redirect && (count + inflight < DEPTH). On issue, register inflight_pc<=fetch_pc, set inflight<=1, and fetch_pc<=fetch_pc+PC_STEP (32-bit wrap, no flag). With no issue, inflight<=0.
- Response: when inflight=1 in a cycle and no redirect in that cycle, push {inflight_pc, imem_instr} at the edge.
- Latency: a request in cycle N is pushed at the end of cycle N+1 and appears on out_* in cycle N+2 if the FIFO was empty.
- Pop: on out_valid && out_ready, advance the read pointer.
- Push and pop in the same cycle: count is unchanged.
- The credit rule guarantees a push never meets a full FIFO. A pop does not grant same-cycle credit.
- Redirect (highest priority), at the edge:
  - count<=0 and pointers<=0.
  - inflight<=0; the pending response is discarded.
  - fetch_pc<=redirect_pc.
  - imem_req=0 in the redirect cycle; the target is requested in the next cycle.
  - A pop handshake in the redirect cycle is still valid for decode. The FIFO is cleared regardless.
- Back-to-back redirects: the last one wins. No fetch is issued until the first cycle with redirect=0.
- out_ready held low: the FIFO fills to DEPTH and imem_req stays 0 until a pop occurs. Head values stay stable while out_valid && !out_ready.
- Reset asserted mid-operation: all state clears immediately, and the next fetch after release is RESET_PC.
- Sequential states are implicit and fully described by (count, inflight, fetch_pc). There is no separate FSM.

Decomposition:
- Shared package legv8_fetch_pkg holds:
  - RESET_PC and PC_STEP defaults
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}
  - width constants (ADDR_W=32, INSTR_W=32)
- One sub-module, legv8_fetch_fifo: a synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full. The top module holds the PC, credit logic and inflight tracking.

Test Plan:
1. Reset release, out_ready=1, imem returns mem[a]=a+100 → imem_addr 0,1,2,...; out_pc=0 with out_instr=100 in cycle 2 after release, then one instruction per cycle with incrementing PC.
2. out_ready=0 for 10 cycles, DEPTH=4 → occupancy climbs to 4; imem_req=0 once count+inflight=4; fetch_pc=4; out_pc held at 0.
3. Raise out_ready after a full stall → one pop per cycle; issue resumes and imem_addr continues from 4 with no PC skipped or duplicated.
4. redirect with redirect_pc=0x40 while occupancy=3 and inflight=1 → occupancy 0 next cycle; imem_req=0 in the redirect cycle; next imem_addr=0x40; first out_pc=0x40; none of the old PCs ever appear.
5. redirect in two consecutive cycles (0x80, then 0xC0) → no request for 0x80 is issued; first fetched PC is 0xC0.
6. reset asserted asynchronously mid-stream with occupancy=2 → out_valid and occupancy drop to 0 without a clock edge; after release, fetch restarts at RESET_PC.
